// File: rtl/ps_window_linebuffer_if.sv
// Handshake/data bundle between the pixel ingest, the line buffer and the kernel datapath.
// The slave modport is the line buffer's own view of the bundle.
interface ps_window_linebuffer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAPS       = 3,
  parameter int unsigned NUM_BANKS  = 2
);
  localparam int unsigned CNT_W = $clog2(NUM_BANKS + 1);

  logic                         i_wr;
  logic [DATA_WIDTH-1:0]        i_wdata;
  logic                         o_wr_ready;
  logic                         i_rd;
  logic                         o_rd_ready;
  logic [TAPS*DATA_WIDTH-1:0]   o_rdata;
  logic                         o_rvalid;
  logic                         o_rlast;
  logic [CNT_W-1:0]             o_full_cnt;
  logic                         o_ovf;
  logic                         o_udf;

  modport master (
    output i_wr, i_wdata, i_rd,
    input  o_wr_ready, o_rd_ready, o_rdata, o_rvalid, o_rlast, o_full_cnt, o_ovf, o_udf
  );

  modport slave (
    input  i_wr, i_wdata, i_rd,
    output o_wr_ready, o_rd_ready, o_rdata, o_rvalid, o_rlast, o_full_cnt, o_ovf, o_udf
  );
endinterface

// File: rtl/ps_window_linebuffer.sv
// Ring of line banks: the writer fills whole lines, the reader walks a completed line
// and gets a TAPS-wide horizontal window per read with selectable edge handling.
module ps_window_linebuffer #(
  parameter int unsigned LINE_LENGTH = 640,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TAPS        = 3,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned EDGE_MODE   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  ps_window_linebuffer_if.slave bus
);
  localparam int unsigned HALF = (TAPS - 1) / 2;
  localparam int unsigned PW   = $clog2(LINE_LENGTH);
  localparam int unsigned IW   = PW + 1;
  localparam int unsigned BW   = $clog2(NUM_BANKS);
  localparam int unsigned CW   = $clog2(NUM_BANKS + 1);
  localparam int unsigned RW   = TAPS * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][LINE_LENGTH];

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [BW-1:0] wbank_q, wbank_d, rbank_q, rbank_d;
  logic [CW-1:0] full_cnt_q, full_cnt_d;
  logic [RW-1:0] rdata_q, rdata_d, win_c;
  logic          rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;

  logic wr_ready_c, rd_ready_c, wr_acc_c, rd_acc_c, wr_done_c, rd_done_c;

  assign wr_ready_c = (full_cnt_q < CW'(NUM_BANKS));
  assign rd_ready_c = (full_cnt_q != '0);
  assign wr_acc_c   = bus.i_wr & wr_ready_c;
  assign rd_acc_c   = bus.i_rd & rd_ready_c;
  assign wr_done_c  = wr_acc_c & (wptr_q == PW'(LINE_LENGTH - 1));
  assign rd_done_c  = rd_acc_c & (rptr_q == PW'(LINE_LENGTH - 1));

  // Window taps: slice s holds the word at offset HALF-s from the centre.
  for (genvar s = 0; s < int'(TAPS); s++) begin : g_tap
    localparam int OFF = int'(HALF) - s;
    logic signed [IW-1:0] j;
    logic [PW-1:0]        a;
    logic                 oob_lo, oob_hi;

    assign j      = $signed({1'b0, rptr_q}) + IW'(OFF);
    assign oob_lo = (j < 0);
    assign oob_hi = (j > IW'(int'(LINE_LENGTH) - 1));

    always_comb begin
      a = PW'(j);
      if (oob_lo) begin
        a = (EDGE_MODE == 0) ? PW'(j + IW'(int'(LINE_LENGTH))) : '0;
      end else if (oob_hi) begin
        a = (EDGE_MODE == 0) ? PW'(j - IW'(int'(LINE_LENGTH))) : PW'(LINE_LENGTH - 1);
      end
    end

    assign win_c[s*DATA_WIDTH +: DATA_WIDTH] =
      ((EDGE_MODE == 2) && (oob_lo || oob_hi)) ? '0 : mem_q[rbank_q][a];
  end

  always_ff @(posedge i_clk) begin
    if (i_rstn && wr_acc_c) mem_q[wbank_q][wptr_q] <= bus.i_wdata;
  end

  always_comb begin
    wptr_d     = wptr_q;
    wbank_d    = wbank_q;
    rptr_d     = rptr_q;
    rbank_d    = rbank_q;
    full_cnt_d = full_cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = rd_acc_c;
    rlast_d    = rd_done_c;
    ovf_d      = bus.i_wr & ~wr_ready_c;
    udf_d      = bus.i_rd & ~rd_ready_c;

    if (wr_acc_c) begin
      wptr_d = wptr_q + PW'(1);
      if (wr_done_c) begin
        wptr_d  = '0;
        wbank_d = (wbank_q == BW'(NUM_BANKS - 1)) ? '0 : wbank_q + BW'(1);
      end
    end

    if (rd_acc_c) begin
      rdata_d = win_c;
      rptr_d  = rptr_q + PW'(1);
      if (rd_done_c) begin
        rptr_d  = '0;
        rbank_d = (rbank_q == BW'(NUM_BANKS - 1)) ? '0 : rbank_q + BW'(1);
      end
    end

    // A line completing and a line releasing in the same cycle cancel out.
    case ({wr_done_c, rd_done_c})
      2'b10:   full_cnt_d = full_cnt_q + CW'(1);
      2'b01:   full_cnt_d = full_cnt_q - CW'(1);
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wptr_q     <= '0;
      wbank_q    <= '0;
      rptr_q     <= '0;
      rbank_q    <= '0;
      full_cnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      wbank_q    <= wbank_d;
      rptr_q     <= rptr_d;
      rbank_q    <= rbank_d;
      full_cnt_q <= full_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign bus.o_wr_ready = wr_ready_c;
  assign bus.o_rd_ready = rd_ready_c;
  assign bus.o_rdata    = rdata_q;
  assign bus.o_rvalid   = rvalid_q;
  assign bus.o_rlast    = rlast_q;
  assign bus.o_full_cnt = full_cnt_q;
  assign bus.o_ovf      = ovf_q;
  assign bus.o_udf      = udf_q;
endmodule

// File: tb/tb_ps_window_linebuffer.sv
// Bench for ps_window_linebuffer: four configurations share one stimulus stream and are
// checked every cycle against a line-queue model, plus hand-computed window literals.
module tb_ps_window_linebuffer;
  localparam int LL = 640;
  localparam int NB = 2;
  localparam int NI = 4;

  typedef logic [7:0] line_t [LL];

  logic       clk = 1'b0;
  logic       rstn, wr, rd, chk_en;
  logic [7:0] wdata;
  int         n_tests = 0;
  int         n_fail  = 0;

  initial forever #5 clk = ~clk;

  // Instance configs: 0 TAPS3 clamp, 1 TAPS5 clamp, 2 TAPS3 wrap, 3 TAPS3 zero-pad.
  function automatic int taps_of(int i);
    return (i == 1) ? 5 : 3;
  endfunction
  function automatic int mode_of(int i);
    case (i)
      2:       return 0;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  ps_window_linebuffer_if #(.DATA_WIDTH(8), .TAPS(3), .NUM_BANKS(NB)) b0 ();
  ps_window_linebuffer_if #(.DATA_WIDTH(8), .TAPS(5), .NUM_BANKS(NB)) b1 ();
  ps_window_linebuffer_if #(.DATA_WIDTH(8), .TAPS(3), .NUM_BANKS(NB)) b2 ();
  ps_window_linebuffer_if #(.DATA_WIDTH(8), .TAPS(3), .NUM_BANKS(NB)) b3 ();

  assign b0.i_wr = wr;  assign b0.i_wdata = wdata;  assign b0.i_rd = rd;
  assign b1.i_wr = wr;  assign b1.i_wdata = wdata;  assign b1.i_rd = rd;
  assign b2.i_wr = wr;  assign b2.i_wdata = wdata;  assign b2.i_rd = rd;
  assign b3.i_wr = wr;  assign b3.i_wdata = wdata;  assign b3.i_rd = rd;

  ps_window_linebuffer #(.LINE_LENGTH(LL), .DATA_WIDTH(8), .TAPS(3), .NUM_BANKS(NB), .EDGE_MODE(1))
    u0 (.i_clk(clk), .i_rstn(rstn), .bus(b0.slave));
  ps_window_linebuffer #(.LINE_LENGTH(LL), .DATA_WIDTH(8), .TAPS(5), .NUM_BANKS(NB), .EDGE_MODE(1))
    u1 (.i_clk(clk), .i_rstn(rstn), .bus(b1.slave));
  ps_window_linebuffer #(.LINE_LENGTH(LL), .DATA_WIDTH(8), .TAPS(3), .NUM_BANKS(NB), .EDGE_MODE(0))
    u2 (.i_clk(clk), .i_rstn(rstn), .bus(b2.slave));
  ps_window_linebuffer #(.LINE_LENGTH(LL), .DATA_WIDTH(8), .TAPS(3), .NUM_BANKS(NB), .EDGE_MODE(2))
    u3 (.i_clk(clk), .i_rstn(rstn), .bus(b3.slave));

  logic [39:0] act_rd  [NI];
  logic [7:0]  act_ctl [NI];
  assign act_rd[0] = 40'(b0.o_rdata);
  assign act_rd[1] = 40'(b1.o_rdata);
  assign act_rd[2] = 40'(b2.o_rdata);
  assign act_rd[3] = 40'(b3.o_rdata);
  assign act_ctl[0] = {b0.o_wr_ready, b0.o_rd_ready, b0.o_rvalid, b0.o_rlast, b0.o_ovf, b0.o_udf, b0.o_full_cnt};
  assign act_ctl[1] = {b1.o_wr_ready, b1.o_rd_ready, b1.o_rvalid, b1.o_rlast, b1.o_ovf, b1.o_udf, b1.o_full_cnt};
  assign act_ctl[2] = {b2.o_wr_ready, b2.o_rd_ready, b2.o_rvalid, b2.o_rlast, b2.o_ovf, b2.o_udf, b2.o_full_cnt};
  assign act_ctl[3] = {b3.o_wr_ready, b3.o_rd_ready, b3.o_rvalid, b3.o_rlast, b3.o_ovf, b3.o_udf, b3.o_full_cnt};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window of a stored line: MSB slice is idx-h, LSB slice is idx+h.
  function automatic logic [39:0] window(input line_t l, input int idx, input int taps, input int mode);
    int h;
    logic [39:0] r;
    h = (taps - 1) / 2;
    r = '0;
    for (int k = -h; k <= h; k++) begin
      int j;
      logic [7:0] v;
      j = idx + k;
      if (j >= 0 && j < LL)  v = l[j];
      else if (mode == 0)    v = l[(j + LL) % LL];
      else if (mode == 1)    v = (j < 0) ? l[0] : l[LL-1];
      else                   v = 8'h00;
      r[(h - k)*8 +: 8] = v;
    end
    return r;
  endfunction

  // Model: queue of completed lines, a partial line, and a read position.
  line_t       done_q[$];
  line_t       part;
  int          wp, rp;
  logic [39:0] exp_rd [NI];
  logic        e_rvalid, e_rlast, e_ovf, e_udf, wok, rok, completed;

  always @(posedge clk) begin
    if (!rstn) begin
      done_q.delete();
      wp = 0; rp = 0;
      for (int i = 0; i < NI; i++) exp_rd[i] = '0;
      e_rvalid = 0; e_rlast = 0; e_ovf = 0; e_udf = 0;
    end else begin
      wok = (done_q.size() < NB);
      rok = (done_q.size() != 0);
      completed = 0;
      e_ovf    = wr && !wok;
      e_udf    = rd && !rok;
      e_rvalid = rd && rok;
      e_rlast  = e_rvalid && (rp == LL - 1);
      if (rd && rok)
        for (int i = 0; i < NI; i++) exp_rd[i] = window(done_q[0], rp, taps_of(i), mode_of(i));
      if (wr && wok) begin
        part[wp] = wdata;
        if (wp == LL - 1) begin wp = 0; completed = 1; end
        else wp++;
      end
      if (rd && rok) begin
        if (rp == LL - 1) begin rp = 0; void'(done_q.pop_front()); end
        else rp++;
      end
      if (completed) done_q.push_back(part);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("u%0d rdata", i), 64'(act_rd[i]), 64'(exp_rd[i]));
        chk($sformatf("u%0d ctl{wrdy,rrdy,rv,rl,ovf,udf,cnt}", i), 64'(act_ctl[i]),
            64'({done_q.size() < NB, done_q.size() != 0, e_rvalid, e_rlast, e_ovf, e_udf, 2'(done_q.size())}));
      end
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr = w; wdata = d; rd = r;
    @(negedge clk);
  endtask

  logic [39:0] cap [NI][LL];

  initial begin
    rstn = 1'b0; wr = 1'b0; rd = 1'b1; wdata = '0; chk_en = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1; chk_en = 1'b1;
    chk("reset full_cnt", 64'(b0.o_full_cnt), 64'd0);
    chk("reset rdata", 64'(act_rd[0]), 64'd0);

    // Read on an empty buffer right after reset.
    cyc(1'b0, 8'h00, 1'b1);
    chk("empty read udf", 64'(b0.o_udf), 64'd1);
    chk("empty read rvalid", 64'(b0.o_rvalid), 64'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("udf single pulse", 64'(b0.o_udf), 64'd0);

    // One line 0..639, then read it all.
    for (int i = 0; i < LL; i++) cyc(1'b1, 8'(i), 1'b0);
    wr = 1'b0;
    chk("line1 full_cnt", 64'(b0.o_full_cnt), 64'd1);
    for (int i = 0; i < LL; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      for (int n = 0; n < NI; n++) cap[n][i] = act_rd[n];
      if (i == LL - 1) chk("read639 rlast", 64'(b0.o_rlast), 64'd1);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("clamp read0",    64'(cap[0][0]),   64'h000001);
    chk("clamp read5",    64'(cap[0][5]),   64'h040506);
    chk("clamp read639",  64'(cap[0][639]), 64'h7E7F7F);
    chk("t5 read1",       64'(cap[1][1]),   64'h0000010203);
    chk("t5 read638",     64'(cap[1][638]), 64'h7C7D7E7F7F);
    chk("wrap read0",     64'(cap[2][0]),   64'h7F0001);
    chk("wrap read639",   64'(cap[2][639]), 64'h7E7F00);
    chk("zpad read0",     64'(cap[3][0]),   64'h000001);
    chk("zpad read639",   64'(cap[3][639]), 64'h7E7F00);
    chk("drained rd_ready", 64'(b0.o_rd_ready), 64'd0);

    // Fill both banks, then overflow.
    for (int i = 0; i < 2*LL; i++) cyc(1'b1, 8'(i + 100), 1'b0);
    wr = 1'b0;
    chk("full wr_ready", 64'(b0.o_wr_ready), 64'd0);
    chk("full full_cnt", 64'(b0.o_full_cnt), 64'd2);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("overflow ovf", 64'(b0.o_ovf), 64'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf single pulse", 64'(b0.o_ovf), 64'd0);
    for (int i = 0; i < LL; i++) cyc(1'b0, 8'h00, 1'b1);
    rd = 1'b0;
    chk("after release wr_ready", 64'(b0.o_wr_ready), 64'd1);
    chk("after release full_cnt", 64'(b0.o_full_cnt), 64'd1);

    // Write a new line while reading the remaining one; last write and last read coincide.
    for (int i = 0; i < LL; i++) cyc(1'b1, 8'(i*7 + 3), 1'b1);
    chk("concurrent full_cnt", 64'(b0.o_full_cnt), 64'd1);
    chk("concurrent rlast", 64'(b0.o_rlast), 64'd1);
    for (int i = 0; i < LL; i++) cyc(1'b0, 8'h00, 1'b1);
    rd = 1'b0;

    // Mid-stream reset.
    for (int i = 0; i < LL; i++) cyc(1'b1, 8'(i) ^ 8'h5A, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'(i + 1), (i < 100));
    rstn = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    rstn = 1'b1;
    chk("rst rvalid",   64'(b0.o_rvalid),   64'd0);
    chk("rst full_cnt", 64'(b0.o_full_cnt), 64'd0);
    chk("rst rd_ready", 64'(b0.o_rd_ready), 64'd0);
    chk("rst wr_ready", 64'(b0.o_wr_ready), 64'd1);
    chk("rst rdata",    64'(act_rd[0]),     64'd0);

    // Fresh line reads from word 0.
    for (int i = 0; i < LL; i++) cyc(1'b1, 8'(i*5), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fresh clamp read0", 64'(act_rd[0]), 64'h000005);
    chk("fresh wrap read0",  64'(act_rd[2]), 64'h7B0005);
    for (int i = 1; i < LL; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
